// File: rtl/cache_fill_ctrl.sv
// Miss handler shared by the I- and D-caches: grants the memory port with D priority,
// streams an 8-word block into the owner's data array, then writes its tag entry.
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              i_write_data_en,
  output logic              i_write_tag_en,
  output logic              d_write_data_en,
  output logic              d_write_tag_en,
  output logic              i_sel,
  output logic              d_sel,
  output logic              busy
);

  localparam int BLK_W = ADDR_W - CNT_W - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_TAG,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [BLK_W-1:0]   blk_addr_q, blk_addr_d;
  logic               owner_q, owner_d;   // 1 = D-cache, 0 = I-cache
  logic               mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               i_sel_q, i_sel_d;
  logic               d_sel_q, d_sel_d;
  logic               i_tag_q, i_tag_d;
  logic               d_tag_q, d_tag_d;
  logic               busy_q, busy_d;

  logic               rx_fire;
  logic [BLK_W-1:0]   win_blk;
  logic [CNT_W-1:0]   issue_nxt;
  logic               unused_low_bits;

  assign unused_low_bits = ^{i_miss_addr[CNT_W:0], d_miss_addr[CNT_W:0]};

  // A return seen in the first FILL cycle can only be left over from before a reset.
  assign rx_fire   = (state_q == ST_FILL) && mem_data_valid && (issue_cnt_q != '0);
  assign win_blk   = d_miss ? d_miss_addr[ADDR_W-1:CNT_W+1] : i_miss_addr[ADDR_W-1:CNT_W+1];
  assign issue_nxt = issue_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    blk_addr_d  = blk_addr_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    i_sel_d     = i_sel_q;
    d_sel_d     = d_sel_q;
    i_tag_d     = 1'b0;
    d_tag_d     = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (d_miss || i_miss) begin
          state_d     = ST_FILL;
          owner_d     = d_miss;
          blk_addr_d  = win_blk;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          mem_en_d    = 1'b1;
          mem_addr_d  = {win_blk, {(CNT_W + 1){1'b0}}};
          i_sel_d     = ~d_miss;
          d_sel_d     = d_miss;
          busy_d      = 1'b1;
        end
      end
      ST_FILL: begin
        if (mem_en_q) begin
          if (issue_cnt_q == LAST) begin
            mem_en_d = 1'b0;
          end else begin
            issue_cnt_d = issue_nxt;
            mem_addr_d  = {blk_addr_q, issue_nxt, 1'b0};
          end
        end
        if (rx_fire) begin
          if (rcv_cnt_q == LAST) begin
            state_d = ST_TAG;
            i_tag_d = ~owner_q;
            d_tag_d = owner_q;
          end else begin
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_TAG: begin
        state_d  = ST_DONE;
        mem_en_d = 1'b0;
        i_sel_d  = 1'b0;
        d_sel_d  = 1'b0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        i_sel_d  = 1'b0;
        d_sel_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      blk_addr_q  <= '0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      i_sel_q     <= 1'b0;
      d_sel_q     <= 1'b0;
      i_tag_q     <= 1'b0;
      d_tag_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      blk_addr_q  <= blk_addr_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      i_sel_q     <= i_sel_d;
      d_sel_q     <= d_sel_d;
      i_tag_q     <= i_tag_d;
      d_tag_q     <= d_tag_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en          = mem_en_q;
  assign mem_addr        = mem_addr_q;
  assign i_sel           = i_sel_q;
  assign d_sel           = d_sel_q;
  assign busy            = busy_q;
  assign i_write_tag_en  = i_tag_q;
  assign d_write_tag_en  = d_tag_q;
  // Data writes land in the same cycle as the memory return, so they cannot be registered.
  assign i_write_data_en = rx_fire & ~owner_q;
  assign d_write_data_en = rx_fire & owner_q;
  assign fill_data       = (state_q == ST_FILL) ? mem_data : 16'h0000;

  always_comb begin
    fill_addr = '0;
    if (state_q == ST_FILL)
      fill_addr = {blk_addr_q, rcv_cnt_q, 1'b0};
    else if (state_q == ST_TAG)
      fill_addr = {blk_addr_q, {(CNT_W + 1){1'b0}}};
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with a 4-cycle pipelined memory model.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr, mem_data, fill_addr, fill_data;
  logic        mem_data_valid;
  logic        i_wde, i_wte, d_wde, d_wte, i_sel, d_sel, busy;
  logic        force_valid = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cache_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .i_write_data_en(i_wde),
    .i_write_tag_en (i_wte),
    .d_write_data_en(d_wde),
    .d_write_tag_en (d_wte),
    .i_sel          (i_sel),
    .d_sel          (d_sel),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[11:4] ^ 8'h23, 1'b0, a[3:1], 4'h0};
  endfunction

  // Memory: request seen in cycle q returns data in cycle q+4; not reset by rst.
  logic [3:0]  pv = 4'b0000;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv <= {pv[2:0], mem_en};
    pa[0] <= mem_addr;
    for (int k = 1; k < 4; k++) pa[k] <= pa[k-1];
  end
  assign mem_data_valid = pv[3] | force_valid;
  assign mem_data       = pv[3] ? memf(pa[3]) : 16'h0000;

  typedef struct {
    int          c;
    bit          tag;
    bit          dc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  typedef struct {
    int          c;
    logic [15:0] addr;
  } iss_t;
  wr_t  wr_q[$];
  iss_t iss_q[$];

  task automatic exp_fill(input bit dc, input logic [15:0] a, input int p,
                          input int nwords, input bit tag);
    logic [15:0] base, wa;
    base = {a[15:4], 4'h0};
    for (int n = 0; n < 8; n++) begin
      wa = base + 16'(2 * n);
      iss_q.push_back('{p + 1 + n, wa});
    end
    for (int n = 0; n < nwords; n++) begin
      wa = base + 16'(2 * n);
      wr_q.push_back('{p + 5 + n, 1'b0, dc, wa, memf(wa)});
    end
    if (tag) wr_q.push_back('{p + 13, 1'b1, dc, base, 16'h0000});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    wr_t  e;
    iss_t s;
    bit   any_w, g_tag, g_dc;
    any_w = i_wde | i_wte | d_wde | d_wte;
    g_tag = i_wte | d_wte;
    g_dc  = d_wde | d_wte;
    total++;
    if (((i_wde | i_wte) && (d_wde | d_wte)) || ((i_wde | d_wde) && (i_wte | d_wte))) begin
      bad++;
      $display("FAIL excl cyc=%0d got iwd=%b iwt=%b dwd=%b dwt=%b", cyc, i_wde, i_wte, d_wde, d_wte);
    end
    if (any_w) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexp_write cyc=%0d got tag=%b dc=%b addr=%h exp none", cyc, g_tag, g_dc, fill_addr);
      end else begin
        e = wr_q.pop_front();
        if (cyc != e.c || g_tag != e.tag || g_dc != e.dc || fill_addr !== e.addr ||
            (!g_tag && fill_data !== e.data)) begin
          bad++;
          $display("FAIL write cyc=%0d got tag=%b dc=%b addr=%h data=%h exp cyc=%0d tag=%b dc=%b addr=%h data=%h",
                   cyc, g_tag, g_dc, fill_addr, fill_data, e.c, e.tag, e.dc, e.addr, e.data);
        end
      end
    end
    if (mem_en === 1'b1) begin
      total++;
      if (iss_q.size() == 0) begin
        bad++;
        $display("FAIL unexp_issue cyc=%0d got addr=%h exp none", cyc, mem_addr);
      end else begin
        s = iss_q.pop_front();
        if (cyc != s.c || mem_addr !== s.addr) begin
          bad++;
          $display("FAIL issue cyc=%0d got addr=%h exp cyc=%0d addr=%h", cyc, mem_addr, s.c, s.addr);
        end
      end
    end
  end

  initial begin
    int p, p2;
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0;
    #2;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'({i_sel, d_sel}), 32'd0);
    chk("rst_fill_addr", 32'(fill_addr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    to_cyc(cyc + 2);

    // Single I miss
    p = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    exp_fill(1'b0, 16'h1234, p, 8, 1'b1);
    to_cyc(p + 1);
    i_miss = 1'b0;
    chk("t1_isel", 32'({i_sel, d_sel}), 32'b10);
    chk("t1_busy_first", 32'(busy), 32'd1);
    to_cyc(p + 13);
    chk("t1_isel_tag", 32'(i_sel), 32'd1);
    to_cyc(p + 14);
    chk("t1_busy_done", 32'(busy), 32'd1);
    chk("t1_isel_done", 32'(i_sel), 32'd0);
    to_cyc(p + 15);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    to_cyc(p + 20);

    // Simultaneous misses: D wins
    p = cyc;
    d_miss = 1'b1; d_miss_addr = 16'h5432;
    i_miss = 1'b1; i_miss_addr = 16'h1A34;
    exp_fill(1'b1, 16'h5432, p, 8, 1'b1);
    exp_fill(1'b0, 16'h1A34, p + 15, 8, 1'b1);
    to_cyc(p + 1);
    d_miss = 1'b0;
    chk("t2_dsel", 32'({i_sel, d_sel}), 32'b01);
    to_cyc(p + 16);
    i_miss = 1'b0;
    chk("t2_isel", 32'({i_sel, d_sel}), 32'b10);
    to_cyc(p + 32);

    // I miss arriving in the 3rd cycle of a D fill
    p = cyc;
    d_miss = 1'b1; d_miss_addr = 16'h7778;
    exp_fill(1'b1, 16'h7778, p, 8, 1'b1);
    to_cyc(p + 1);
    d_miss = 1'b0;
    to_cyc(p + 3);
    i_miss = 1'b1; i_miss_addr = 16'h0ABC;
    exp_fill(1'b0, 16'h0ABC, p + 15, 8, 1'b1);
    chk("t3_dsel_kept", 32'({i_sel, d_sel}), 32'b01);
    to_cyc(p + 16);
    i_miss = 1'b0;
    to_cyc(p + 32);

    // Back-to-back I misses, same index, different tag
    p = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    exp_fill(1'b0, 16'h1234, p, 8, 1'b1);
    to_cyc(p + 1);
    i_miss_addr = 16'h1A34;
    exp_fill(1'b0, 16'h1A34, p + 15, 8, 1'b1);
    to_cyc(p + 14);
    chk("t4_done_busy", 32'(busy), 32'd1);
    chk("t4_done_sel", 32'(i_sel), 32'd0);
    to_cyc(p + 15);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    to_cyc(p + 16);
    i_miss = 1'b0;
    to_cyc(p + 32);

    // Reset after 4 words received
    p = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h3456;
    exp_fill(1'b0, 16'h3456, p, 4, 1'b0);
    to_cyc(p + 1);
    i_miss = 1'b0;
    to_cyc(p + 8);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_isel", 32'(i_sel), 32'd0);
    chk("t5_fill_addr", 32'(fill_addr), 32'd0);
    to_cyc(p + 10);
    #2;
    rst = 1'b0;
    to_cyc(p + 14);
    p2 = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h3456;
    exp_fill(1'b0, 16'h3456, p2, 8, 1'b1);
    to_cyc(p2 + 1);
    i_miss = 1'b0;
    to_cyc(p2 + 20);

    // Spurious valid in IDLE
    p = cyc;
    #2;
    force_valid = 1'b1;
    #1;
    chk("t6_fill_data", 32'(fill_data), 32'd0);
    chk("t6_wen", 32'({i_wde, d_wde}), 32'd0);
    to_cyc(p + 1);
    #2;
    force_valid = 1'b0;
    to_cyc(p + 2);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mem_en", 32'(mem_en), 32'd0);
    to_cyc(p + 6);

    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
